sgf_division: RTL

SGF_DIVISION -- requirements
Module: sgf_division

---
 rtl/sgf_division.sv | 113 +++++++++++
 1 files changed

// File: rtl/sgf_division.sv
// Restoring bit-serial significand divider.
// One quotient bit per cycle; divide-by-zero bypasses the iteration.
module sgf_division #(
  parameter int SW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [SW-1:0] Data_A_i,
  input  logic [SW-1:0] Data_B_i,
  output logic          busy_o,
  output logic          ready_o,
  output logic [SW+1:0] sgf_result_o,
  output logic          sticky_o,
  output logic          dz_o
);

  localparam int CW = $clog2(SW + 2);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW:0]   r_rem;
  logic [SW:0]   r_div;
  logic [SW+1:0] r_quo;
  logic [SW+1:0] r_res;
  logic [CW-1:0] r_cnt;
  logic          r_sticky;
  logic          r_dz;

  logic          w_q;
  logic [SW:0]   w_diff;
  logic [SW:0]   w_rem_nxt;
  logic          w_last;
  logic          w_bzero;

  assign w_q       = (r_rem >= r_div);
  assign w_diff    = w_q ? (r_rem - r_div) : r_rem;
  assign w_rem_nxt = {w_diff[SW-1:0], 1'b0};
  assign w_last    = (r_cnt == CW'(SW + 1));
  assign w_bzero   = (Data_B_i == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start_i) w_next = w_bzero ? DONE : CALC;
      end
      CALC: begin
        if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Results are only rewritten on acceptance (dz) or on the last step,
  // so they hold from ready_o until the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem    <= '0;
      r_div    <= '0;
      r_quo    <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_rem <= {1'b0, Data_A_i};
            r_div <= {1'b0, Data_B_i};
            r_quo <= '0;
            r_cnt <= '0;
            r_dz  <= w_bzero;
            if (w_bzero) begin
              r_res    <= '1;
              r_sticky <= 1'b0;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[SW:0], w_q};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_res    <= {r_quo[SW:0], w_q};
            r_sticky <= |w_diff;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o       = (r_state != IDLE);
  assign ready_o      = (r_state == DONE);
  assign sgf_result_o = r_res;
  assign sticky_o     = r_sticky;
  assign dz_o         = r_dz;

endmodule
